// File: rtl/lif_neuron_param.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_param
// Purpose  : Parametrised leaky integrate-and-fire neuron. On every cycle
//            with en=1 the membrane potential leaks by a run-time shift,
//            integrates the input current with saturation, and is compared
//            against a threshold. A firing step emits a one-clock spike.
//            It then resets the membrane to zero or subtracts the threshold,
//            and can enter a refractory period of refrac_len en-steps.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    : membrane / current / threshold width (unsigned)
//   LEAK_W   : width of leak_shift
//   REFRAC_W : width of refractory length and counter
// Ports
//   clk         in   clock
//   reset_n     in   synchronous reset, active-low
//   en          in   time-step strobe; state advances only when en=1
//   current     in   input current for this step
//   threshold   in   firing threshold; 0 disables firing
//   leak_shift  in   decay shift (leaked = state >> leak_shift)
//   reset_mode  in   0: reset-to-zero on spike, 1: subtract threshold
//   refrac_len  in   refractory length in en-steps; 0 = none
//   state       out  membrane potential (registered)
//   spike       out  one-clock pulse after a firing step (registered)
//   refractory  out  high while the neuron is refractory (registered)
//   spike_count out  saturating 16-bit spike counter
//                    (present only when LIF_SPIKE_COUNT_EN is defined)
// Optional feature macro: LIF_SPIKE_COUNT_EN
// ============================================================================
module lif_neuron_param #(
    parameter int WIDTH    = 8,
    parameter int LEAK_W   = 3,
    parameter int REFRAC_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    current,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [LEAK_W-1:0]   leak_shift,
    input  logic                reset_mode,
    input  logic [REFRAC_W-1:0] refrac_len,
    output logic [WIDTH-1:0]    state,
    output logic                spike,
    output logic                refractory
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [15:0]         spike_count
`endif
);

    typedef enum logic [0:0] {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } fsm_t;

    localparam logic [WIDTH-1:0]    C_SAT_MAX = {WIDTH{1'b1}};
    localparam logic [REFRAC_W-1:0] C_CNT_ONE = REFRAC_W'(1);

    fsm_t                fsm_q;
    logic [WIDTH-1:0]    state_q;
    logic                spike_q;
    logic                refractory_q;
    logic [REFRAC_W-1:0] cnt_q;

    // Combinational datapath feeding the next-state decisions
    logic [WIDTH-1:0]    leaked_d;
    logic [WIDTH:0]      sum_wide_d;
    logic [WIDTH-1:0]    sum_sat_d;
    logic                fire_d;
    logic [WIDTH-1:0]    fire_state_d;

    always_comb begin
        leaked_d   = state_q >> leak_shift;
        // One extra bit catches the carry so saturation replaces wrap-around.
        sum_wide_d = {1'b0, current} + {1'b0, leaked_d};
        sum_sat_d  = sum_wide_d[WIDTH] ? C_SAT_MAX : sum_wide_d[WIDTH-1:0];
        // A zero threshold would make every step fire, so it disables firing.
        fire_d     = (threshold != '0) && (sum_sat_d >= threshold);
        // sum_sat_d >= threshold whenever this value is used, so no underflow.
        fire_state_d = reset_mode ? (sum_sat_d - threshold) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q        <= ST_INTEGRATE;
            state_q      <= '0;
            spike_q      <= 1'b0;
            refractory_q <= 1'b0;
            cnt_q        <= '0;
        end else if (!en) begin
            spike_q <= 1'b0;
        end else begin
            case (fsm_q)
                ST_INTEGRATE: begin
                    if (fire_d) begin
                        spike_q <= 1'b1;
                        state_q <= fire_state_d;
                        // refrac_len is captured only here; later changes
                        // do not disturb a running refractory count.
                        if (refrac_len != '0) begin
                            cnt_q        <= refrac_len;
                            refractory_q <= 1'b1;
                            fsm_q        <= ST_REFRACT;
                        end
                    end else begin
                        spike_q <= 1'b0;
                        state_q <= sum_sat_d;
                    end
                end
                ST_REFRACT: begin
                    // Input current is ignored and the membrane holds.
                    spike_q <= 1'b0;
                    if (cnt_q == C_CNT_ONE) begin
                        cnt_q        <= '0;
                        refractory_q <= 1'b0;
                        fsm_q        <= ST_INTEGRATE;
                    end else begin
                        cnt_q <= cnt_q - C_CNT_ONE;
                    end
                end
                default: begin
                    fsm_q        <= ST_INTEGRATE;
                    spike_q      <= 1'b0;
                    refractory_q <= 1'b0;
                    cnt_q        <= '0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign spike      = spike_q;
    assign refractory = refractory_q;

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] spike_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spike_count_q <= '0;
        end else if (en && (fsm_q == ST_INTEGRATE) && fire_d
                     && (spike_count_q != 16'hFFFF)) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_param
// Purpose  : Self-checking bench for lif_neuron_param (WIDTH=8). Each driven
//            step pushes the reference model's prediction into a queue. The
//            entry is popped and compared once the DUT has updated.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_param;

    localparam int WIDTH    = 8;
    localparam int LEAK_W   = 3;
    localparam int REFRAC_W = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                en;
    logic [WIDTH-1:0]    current;
    logic [WIDTH-1:0]    threshold;
    logic [LEAK_W-1:0]   leak_shift;
    logic                reset_mode;
    logic [REFRAC_W-1:0] refrac_len;
    logic [WIDTH-1:0]    state;
    logic                spike;
    logic                refractory;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]         spike_count;
`endif

    always #5 clk = ~clk;

    lif_neuron_param #(
        .WIDTH   (WIDTH),
        .LEAK_W  (LEAK_W),
        .REFRAC_W(REFRAC_W)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .current    (current),
        .threshold  (threshold),
        .leak_shift (leak_shift),
        .reset_mode (reset_mode),
        .refrac_len (refrac_len),
        .state      (state),
        .spike      (spike),
        .refractory (refractory)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_count(spike_count)
`endif
    );

    typedef struct {
        int st;
        int sp;
        int rf;
        int sc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_st  = 0;
    int m_ref = 0;
    int m_cnt = 0;
    int m_sp  = 0;
    int m_rf  = 0;
    int m_sc  = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_step(input int rst, input int e, input int cur,
                              input int thr, input int sh, input int mode,
                              input int rl);
        int sum;
        if (rst != 0) begin
            m_st = 0; m_ref = 0; m_cnt = 0; m_sp = 0; m_rf = 0; m_sc = 0;
        end else if (e == 0) begin
            m_sp = 0;
        end else if (m_ref != 0) begin
            m_sp = 0;
            if (m_cnt == 1) begin
                m_ref = 0; m_rf = 0; m_cnt = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else begin
            sum = cur + (m_st >> sh);
            if (sum > 255) sum = 255;
            if (thr != 0 && sum >= thr) begin
                m_sp = 1;
                m_st = (mode != 0) ? sum - thr : 0;
                if (m_sc < 65535) m_sc = m_sc + 1;
                if (rl != 0) begin
                    m_cnt = rl; m_ref = 1; m_rf = 1;
                end
            end else begin
                m_st = sum;
                m_sp = 0;
            end
        end
    endtask

    // One clock: drive inputs, predict, then compare after the edge.
    // lit_st / lit_sp / lit_rf >= 0 add a check against a hand-derived value.
    task automatic step(input string tag, input int rst, input int e,
                        input int cur, input int thr, input int sh,
                        input int mode, input int rl,
                        input int lit_st, input int lit_sp, input int lit_rf);
        exp_t x;
        @(negedge clk);
        reset_n    = (rst != 0) ? 1'b0 : 1'b1;
        en         = (e != 0);
        current    = WIDTH'(cur);
        threshold  = WIDTH'(thr);
        leak_shift = LEAK_W'(sh);
        reset_mode = (mode != 0);
        refrac_len = REFRAC_W'(rl);
        model_step(rst, e, cur, thr, sh, mode, rl);
        x.st = m_st; x.sp = m_sp; x.rf = m_rf; x.sc = m_sc;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check_val({tag, ".state"}, int'(state), x.st);
        check_val({tag, ".spike"}, int'(spike), x.sp);
        check_val({tag, ".refr"},  int'(refractory), x.rf);
`ifdef LIF_SPIKE_COUNT_EN
        check_val({tag, ".count"}, int'(spike_count), x.sc);
`endif
        if (lit_st >= 0) check_val({tag, ".state_lit"}, int'(state), lit_st);
        if (lit_sp >= 0) check_val({tag, ".spike_lit"}, int'(spike), lit_sp);
        if (lit_rf >= 0) check_val({tag, ".refr_lit"},  int'(refractory), lit_rf);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1 [8];
        int t2 [8];
        int t3 [6];
        int t6 [7];

        reset_n = 1'b0; en = 1'b0; current = '0; threshold = '0;
        leak_shift = '0; reset_mode = 1'b0; refrac_len = '0;

        // Reset state, including reset dominating en
        step("rst0", 1, 1, 200, 0, 0, 0, 0, 0, 0, 0);
        do_reset("rst1");

        // 1: pure leak
        t1 = '{100, 50, 25, 12, 6, 3, 1, 0};
        for (int i = 0; i < 8; i++)
            step("leak", 0, 1, (i == 0) ? 100 : 0, 0, 1, 0, 0, t1[i], 0, 0);

        // 2: constant current toward steady state, en gap freezes state
        do_reset("rst2");
        t2 = '{60, 90, 105, 112, 116, 118, 119, 119};
        for (int i = 0; i < 4; i++)
            step("const", 0, 1, 60, 200, 1, 0, 0, t2[i], 0, 0);
        for (int i = 0; i < 3; i++)
            step("hold", 0, 0, 60, 200, 1, 0, 0, 112, 0, 0);
        for (int i = 4; i < 8; i++)
            step("const", 0, 1, 60, 200, 1, 0, 0, t2[i], 0, 0);

        // 3: fire with reset-to-zero, period 2 steps
        do_reset("rst3");
        t3 = '{100, 0, 100, 0, 100, 0};
        for (int i = 0; i < 6; i++)
            step("fire0", 0, 1, 100, 150, 1, 0, 0, t3[i], i % 2, 0);
        // spike is a single-clock pulse: an idle cycle clears it
        step("fire0_idle", 0, 0, 100, 150, 1, 0, 0, 0, 0, 0);

        // 4: fire with subtract reset
        do_reset("rst4");
        step("sub1", 0, 1, 100, 140, 1, 1, 0, 100, 0, 0);
        step("sub2", 0, 1, 100, 140, 1, 1, 0, 10,  1, 0);
        step("sub3", 0, 1, 100, 140, 1, 1, 0, 105, 0, 0);
        step("sub4", 0, 1, 100, 140, 1, 1, 0, 12,  1, 0);

        // 5: saturation instead of wrap
        do_reset("rst5");
        for (int i = 0; i < 3; i++)
            step("sat255", 0, 1, 255, 0, 0, 0, 0, 255, 0, 0);
        step("sat263", 0, 1, 200, 0, 2, 0, 0, 255, 0, 0);

        // 6: refractory; refrac_len changed mid-period must not matter
        do_reset("rst6");
        t6 = '{100, 0, 0, 0, 0, 100, 0};
        for (int i = 0; i < 7; i++)
            step("refr", 0, 1, 100, 150, 1, 0, (i >= 2 && i <= 4) ? 9 : 3,
                 t6[i], (i == 1 || i == 6) ? 1 : 0,
                 (i >= 1 && i <= 3) || i == 6 ? 1 : 0);
        // en gap during refractory keeps the count frozen
        step("refr_gap", 0, 0, 100, 150, 1, 0, 3, 0, 0, 1);
        step("refr_gap2", 0, 1, 100, 150, 1, 0, 3, 0, 0, 1);

        // 6b: reset during refractory aborts it
        do_reset("rst6b");
        step("ab1", 0, 1, 100, 150, 1, 0, 3, 100, 0, 0);
        step("ab2", 0, 1, 100, 150, 1, 0, 3, 0,   1, 1);
        step("ab3", 0, 1, 100, 150, 1, 0, 3, 0,   0, 1);
        step("ab4", 1, 1, 100, 150, 1, 0, 3, 0,   0, 0);
        step("ab5", 0, 1, 100, 150, 1, 0, 3, 100, 0, 0);

        // Randomised run against the model
        for (int i = 0; i < 200; i++)
            step("rand", ($urandom_range(0, 49) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)), -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
